// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared LED width/brightness constants and helpers
package led_pkg;

    localparam int N_LED_DEFAULT = 16;
    localparam int BW_DEFAULT    = 4;

    // Full-scale brightness code for a given brightness width
    function automatic int bright_max(input int bw);
        return (1 << bw) - 1;
    endfunction

endpackage

// File: rtl/led_pwm_cmp.sv
// rtl/led_pwm_cmp.sv - per-LED brightness vs PWM count compare with full-scale override
module led_pwm_cmp
    import led_pkg::*;
#(
    parameter int BW = BW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BW-1:0] bright,
    input  logic [BW-1:0] pwm_cnt,
    output logic          on
);

    localparam logic [BW-1:0] MAX = BW'(bright_max(BW));

    // The compare is purely combinational; clk/rst_n are kept on the
    // interface so a registered variant can drop in without top changes.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;

    // Full scale is forced steady on so MAX never shows the one-count gap
    always_comb begin
        on = (bright == MAX) | (bright > pwm_cnt);
    end

endmodule

// File: rtl/led_trail_fader.sv
// rtl/led_trail_fader.sv - comet-tail fader: per-LED brightness decay and PWM drive
module led_trail_fader
    import led_pkg::*;
#(
    parameter int N_LED   = N_LED_DEFAULT,
    parameter int BW      = BW_DEFAULT,
    parameter int PWM_DIV = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [N_LED-1:0] pos_in,
    output logic [N_LED-1:0] led
);

    localparam logic [BW-1:0] MAX   = BW'(bright_max(BW));
    localparam int            PRE_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PWM_DIV - 1);

    logic [N_LED-1:0] pos_prev_q, pos_prev_d;
    logic [BW-1:0]    bright_q [N_LED];
    logic [BW-1:0]    bright_d [N_LED];
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [BW-1:0]    pwm_cnt_q, pwm_cnt_d;
    logic [N_LED-1:0] led_q, led_d;
    logic [N_LED-1:0] on;
    logic             chg;
    logic             pre_wrap;

    // One compare per LED against the shared PWM phase
    for (genvar g = 0; g < N_LED; g++) begin : g_cmp
        led_pwm_cmp #(
            .BW(BW)
        ) u_cmp (
            .clk     (clk),
            .rst_n   (rst_n),
            .bright  (bright_q[g]),
            .pwm_cnt (pwm_cnt_q),
            .on      (on[g])
        );
    end

    // Next state: change detect, brightness set/decay, PWM timebase, output mux
    always_comb begin
        chg        = (pos_in != pos_prev_q);
        pos_prev_d = pos_in;
        for (int i = 0; i < N_LED; i++) begin
            bright_d[i] = bright_q[i];
            if (chg) begin
                bright_d[i] = pos_in[i] ? MAX : (bright_q[i] >> 1);
            end
        end
        pre_wrap  = (pre_cnt_q == PRE_LAST);
        pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d = pre_wrap ? pwm_cnt_q + BW'(1) : pwm_cnt_q;
        led_d     = enable ? on : pos_in;
    end

    // State registers; reset clears every piece of fade and PWM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_prev_q <= '0;
            for (int i = 0; i < N_LED; i++) begin
                bright_q[i] <= '0;
            end
            pre_cnt_q  <= '0;
            pwm_cnt_q  <= '0;
            led_q      <= '0;
        end else begin
            pos_prev_q <= pos_prev_d;
            for (int i = 0; i < N_LED; i++) begin
                bright_q[i] <= bright_d[i];
            end
            pre_cnt_q  <= pre_cnt_d;
            pwm_cnt_q  <= pwm_cnt_d;
            led_q      <= led_d;
        end
    end

    assign led = led_q;

endmodule
